// File: rtl/fwd_hist_if.sv
// Operand-forwarding bundle between the ID/EX register, the MEM/WB stages
// and the EX operand muxes.
`timescale 1ns/1ps
interface fwd_hist_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int SW   = 3
);
  logic [AW-1:0]   ex_rs1_addr;
  logic [AW-1:0]   ex_rs2_addr;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [AW-1:0]   mem_rd_addr;
  logic            mem_reg_write;
  logic            mem_is_load;
  logic [XLEN-1:0] mem_data;
  logic [AW-1:0]   wb_rd_addr;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;
  logic            wb_commit;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic [SW-1:0]   fwd_a_src;
  logic [SW-1:0]   fwd_b_src;
  logic            load_use_stall;
  logic [15:0]     stall_cnt;

  // Pipeline side drives the stage information and consumes the operands.
  modport master (
    output ex_rs1_addr, ex_rs2_addr, ex_rs1_data, ex_rs2_data,
    output mem_rd_addr, mem_reg_write, mem_is_load, mem_data,
    output wb_rd_addr, wb_reg_write, wb_data, wb_commit,
    input  ex_op_a, ex_op_b, fwd_a_src, fwd_b_src, load_use_stall, stall_cnt
  );

  modport slave (
    input  ex_rs1_addr, ex_rs2_addr, ex_rs1_data, ex_rs2_data,
    input  mem_rd_addr, mem_reg_write, mem_is_load, mem_data,
    input  wb_rd_addr, wb_reg_write, wb_data, wb_commit,
    output ex_op_a, ex_op_b, fwd_a_src, fwd_b_src, load_use_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hist_unit.sv
// EX-stage operand forwarding from MEM, WB and a short history of committed
// writebacks, with load-use stall detection and a saturating stall counter.
`timescale 1ns/1ps
module fwd_hist_unit #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int HIST_DEPTH = 2,
  parameter int SW         = $clog2(HIST_DEPTH + 3)
) (
  input logic      clk,
  input logic      rst_n,
  fwd_hist_if.slave fwd
);

  typedef struct packed {
    logic [SW-1:0]   src;
    logic [XLEN-1:0] op;
  } fwd_res_t;

  logic [HIST_DEPTH-1:0] hist_valid;
  logic [AW-1:0]         hist_rd   [HIST_DEPTH];
  logic [XLEN-1:0]       hist_data [HIST_DEPTH];

  logic     mem_fwd_ok;
  fwd_res_t res_a;
  fwd_res_t res_b;

  // A load in MEM has no data yet, so it never forwards; it stalls instead.
  assign mem_fwd_ok = fwd.mem_reg_write && !fwd.mem_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_rd[k]   <= '0;
        hist_data[k] <= '0;
      end
    end else if (fwd.wb_commit) begin
      hist_valid[0] <= fwd.wb_reg_write && (fwd.wb_rd_addr != '0);
      hist_rd[0]    <= fwd.wb_rd_addr;
      hist_data[0]  <= fwd.wb_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_valid[k] <= hist_valid[k-1];
        hist_rd[k]    <= hist_rd[k-1];
        hist_data[k]  <= hist_data[k-1];
      end
    end
  end

  // Later assignments override earlier ones, so the youngest producer is
  // applied last: oldest history entry first, MEM at the end.
  function automatic fwd_res_t resolve(input logic [AW-1:0] r,
                                       input logic [XLEN-1:0] rf_data);
    fwd_res_t res;
    res.src = '0;
    res.op  = rf_data;
    for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
      if (hist_valid[k] && (hist_rd[k] == r)) begin
        res.src = SW'(k + 3);
        res.op  = hist_data[k];
      end
    end
    if (fwd.wb_reg_write && (fwd.wb_rd_addr == r)) begin
      res.src = SW'(2);
      res.op  = fwd.wb_data;
    end
    if (mem_fwd_ok && (fwd.mem_rd_addr == r)) begin
      res.src = SW'(1);
      res.op  = fwd.mem_data;
    end
    if (r == '0) begin
      res.src = '0;
      res.op  = rf_data;
    end
    return res;
  endfunction

  always_comb begin
    res_a = resolve(fwd.ex_rs1_addr, fwd.ex_rs1_data);
    res_b = resolve(fwd.ex_rs2_addr, fwd.ex_rs2_data);
  end

  assign fwd.ex_op_a   = res_a.op;
  assign fwd.fwd_a_src = res_a.src;
  assign fwd.ex_op_b   = res_b.op;
  assign fwd.fwd_b_src = res_b.src;

  assign fwd.load_use_stall = fwd.mem_reg_write && fwd.mem_is_load &&
                              (fwd.mem_rd_addr != '0) &&
                              ((fwd.mem_rd_addr == fwd.ex_rs1_addr) ||
                               (fwd.mem_rd_addr == fwd.ex_rs2_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd.stall_cnt <= '0;
    end else if (fwd.load_use_stall && (fwd.stall_cnt != 16'hFFFF)) begin
      fwd.stall_cnt <= fwd.stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hist_unit.sv
// Directed bench for fwd_hist_unit: queue-based reference model compared every
// cycle, plus literal checks on the hand-worked scenarios.
`timescale 1ns/1ps
module tb_fwd_hist_unit;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int HD   = 2;
  localparam int SW   = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fwd_hist_if #(.XLEN(XLEN), .AW(AW), .SW(SW)) bus ();

  fwd_hist_unit #(.XLEN(XLEN), .AW(AW), .HIST_DEPTH(HD), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fwd   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit               v;
    logic [AW-1:0]    rd;
    logic [XLEN-1:0]  d;
  } ent_t;

  ent_t hq[$];
  int   m_cnt;

  function automatic bit model_stall();
    return bus.mem_reg_write && bus.mem_is_load && (bus.mem_rd_addr != 0) &&
           ((bus.mem_rd_addr == bus.ex_rs1_addr) || (bus.mem_rd_addr == bus.ex_rs2_addr));
  endfunction

  function automatic void model_resolve(input logic [AW-1:0] r, input logic [XLEN-1:0] rf,
                                        output logic [SW-1:0] src, output logic [XLEN-1:0] op);
    src = 0;
    op  = rf;
    if (r == 0) return;
    if (bus.mem_reg_write && !bus.mem_is_load && bus.mem_rd_addr == r) begin
      src = 1; op = bus.mem_data; return;
    end
    if (bus.wb_reg_write && bus.wb_rd_addr == r) begin
      src = 2; op = bus.wb_data; return;
    end
    for (int k = 0; k < hq.size(); k++) begin
      if (hq[k].v && hq[k].rd == r) begin
        src = SW'(3 + k); op = hq[k].d; return;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete();
      m_cnt = 0;
    end else begin
      if (model_stall() && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (bus.wb_commit) begin
        ent_t e;
        e.v  = bus.wb_reg_write && (bus.wb_rd_addr != 0);
        e.rd = bus.wb_rd_addr;
        e.d  = bus.wb_data;
        hq.push_front(e);
        if (hq.size() > HD) void'(hq.pop_back());
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [SW-1:0]   ea_src, eb_src;
    logic [XLEN-1:0] ea_op, eb_op;
    model_resolve(bus.ex_rs1_addr, bus.ex_rs1_data, ea_src, ea_op);
    model_resolve(bus.ex_rs2_addr, bus.ex_rs2_data, eb_src, eb_op);
    chk("cyc_op_a",  bus.ex_op_a, ea_op);
    chk("cyc_op_b",  bus.ex_op_b, eb_op);
    chk("cyc_src_a", 32'(bus.fwd_a_src), 32'(ea_src));
    chk("cyc_src_b", 32'(bus.fwd_b_src), 32'(eb_src));
    chk("cyc_stall", 32'(bus.load_use_stall), 32'(model_stall()));
    chk("cyc_cnt",   32'(bus.stall_cnt), 32'(m_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic commit(input logic [AW-1:0] rd, input logic wr, input logic [XLEN-1:0] d);
    bus.wb_rd_addr   = rd;
    bus.wb_reg_write = wr;
    bus.wb_data      = d;
    bus.wb_commit    = 1'b1;
    step();
    bus.wb_commit    = 1'b0;
    bus.wb_reg_write = 1'b0;
    bus.wb_rd_addr   = '0;
  endtask

  task automatic set_mem(input logic [AW-1:0] rd, input logic wr, input logic ld,
                         input logic [XLEN-1:0] d);
    bus.mem_rd_addr   = rd;
    bus.mem_reg_write = wr;
    bus.mem_is_load   = ld;
    bus.mem_data      = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.ex_rs1_addr = '0; bus.ex_rs2_addr = '0;
    bus.ex_rs1_data = '0; bus.ex_rs2_data = '0;
    set_mem('0, 1'b0, 1'b0, '0);
    bus.wb_rd_addr = '0; bus.wb_reg_write = 1'b0; bus.wb_data = '0; bus.wb_commit = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state, no writers
    step();
    bus.ex_rs1_addr = 5; bus.ex_rs1_data = 32'h11;
    #1;
    chk("rst_op_a", bus.ex_op_a, 32'h11);
    chk("rst_src_a", 32'(bus.fwd_a_src), 0);
    chk("rst_stall", 32'(bus.load_use_stall), 0);
    chk("rst_cnt", 32'(bus.stall_cnt), 0);

    // Priority MEM > WB > entry0
    commit(5, 1'b1, 32'hCC);
    bus.wb_rd_addr = 5; bus.wb_reg_write = 1'b1; bus.wb_data = 32'hBB;
    set_mem(5, 1'b1, 1'b0, 32'hAA);
    bus.ex_rs2_addr = 5; bus.ex_rs2_data = 32'h22;
    #1;
    chk("pri_mem_a", bus.ex_op_a, 32'hAA);
    chk("pri_mem_b", bus.ex_op_b, 32'hAA);
    chk("pri_mem_src_a", 32'(bus.fwd_a_src), 1);
    chk("pri_mem_src_b", 32'(bus.fwd_b_src), 1);
    step();
    bus.mem_reg_write = 1'b0;
    #1;
    chk("pri_wb_a", bus.ex_op_a, 32'hBB);
    chk("pri_wb_src_b", 32'(bus.fwd_b_src), 2);
    step();
    bus.wb_reg_write = 1'b0;
    #1;
    chk("pri_h0_b", bus.ex_op_b, 32'hCC);
    chk("pri_h0_src_a", 32'(bus.fwd_a_src), 3);

    // History shift and aging
    bus.ex_rs1_addr = 0; bus.ex_rs2_addr = 0;
    commit(7, 1'b1, 32'h1);
    commit(7, 1'b1, 32'h2);
    commit(7, 1'b1, 32'h3);
    bus.ex_rs2_addr = 7; bus.ex_rs2_data = 32'h77;
    #1;
    chk("hist_e0_op", bus.ex_op_b, 32'h3);
    chk("hist_e0_src", 32'(bus.fwd_b_src), 3);
    commit(3, 1'b0, 32'hDEAD);
    #1;
    chk("hist_e1_op", bus.ex_op_b, 32'h3);
    chk("hist_e1_src", 32'(bus.fwd_b_src), 4);
    commit(0, 1'b0, 32'hBEEF);
    #1;
    chk("hist_gone_op", bus.ex_op_b, 32'h77);
    chk("hist_gone_src", 32'(bus.fwd_b_src), 0);

    // Load-use stall for three cycles
    set_mem(9, 1'b1, 1'b1, 32'h99);
    bus.ex_rs2_addr = 9; bus.ex_rs2_data = 32'h9090;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lu_stall", 32'(bus.load_use_stall), 1);
      chk("lu_src_b", 32'(bus.fwd_b_src), 0);
      step();
    end
    set_mem(0, 1'b0, 1'b0, '0);
    #1;
    chk("lu_cnt", 32'(bus.stall_cnt), 3);
    chk("lu_stall_off", 32'(bus.load_use_stall), 0);

    // x0 never forwards; writes to x0 go into history as invalid entries
    step();
    bus.ex_rs1_addr = 0; bus.ex_rs1_data = 32'h55;
    set_mem(0, 1'b1, 1'b0, 32'hFF);
    #1;
    chk("x0_op_a", bus.ex_op_a, 32'h55);
    chk("x0_src_a", 32'(bus.fwd_a_src), 0);
    set_mem(0, 1'b0, 1'b0, '0);
    bus.ex_rs2_addr = 7; bus.ex_rs2_data = 32'h77;
    commit(7, 1'b1, 32'h3);
    commit(0, 1'b1, 32'h12);
    #1;
    chk("x0_hist_src", 32'(bus.fwd_b_src), 4);
    chk("x0_hist_op", bus.ex_op_b, 32'h3);

    // Bring stall_cnt to 0x10, then reset asynchronously mid-cycle
    set_mem(9, 1'b1, 1'b1, 32'h99);
    bus.ex_rs1_addr = 9;
    for (int i = 0; i < 13; i++) step();
    set_mem(0, 1'b0, 1'b0, '0);
    bus.ex_rs1_addr = 0;
    commit(7, 1'b1, 32'h44);
    #1;
    chk("pre_rst_cnt", 32'(bus.stall_cnt), 32'h10);
    chk("pre_rst_src", 32'(bus.fwd_b_src), 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(bus.stall_cnt), 0);
    chk("async_rst_src", 32'(bus.fwd_b_src), 0);
    chk("async_rst_op", bus.ex_op_b, 32'h77);
    step();
    rst_n = 1'b1;

    // Saturation of stall_cnt
    set_mem(9, 1'b1, 1'b1, 32'h99);
    bus.ex_rs2_addr = 9;
    for (int i = 0; i < 65540; i++) step();
    #1;
    chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
    step();
    set_mem(0, 1'b0, 1'b0, '0);
    step();
    #1;
    chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
